// File: rtl/axi_sram_slave.sv
// AXI3 responder in front of a word-addressed SRAM. Serves one read or write burst
// at a time; AR and AW are granted round-robin when both are pending.
module axi_sram_slave #(
    parameter int MEM_AW  = 16,
    parameter int MAX_LEN = 16
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,

    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN - 1);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t state, state_next;

    logic [31:0] mem [0:(1 << MEM_AW) - 1];

    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  beat_q;
    logic [3:0]  id_q;
    logic        clamp_q;
    logic        err_q;
    logic        rr_pref;   // 0: read has priority, 1: write has priority

    logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic        last_beat;
    logic        wlast_bad;
    logic [31:0] addr_step;
    logic [7:0]  ar_len_eff, aw_len_eff;

    logic unused;
    assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] bt, input logic [7:0] ln);
        logic [31:0] step;
        logic [31:0] total;
        step  = 32'd1 << sz;
        total = ({24'd0, ln} + 32'd1) << sz;
        case (bt)
            2'b00:   return a;
            2'b10:   return (a & ~(total - 32'd1)) | ((a + step) & (total - 32'd1));
            default: return a + step;
        endcase
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
        return a[MEM_AW+1:2];
    endfunction

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign r_hs  = rvalid && rready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    assign last_beat  = (beat_q == len_q);
    assign wlast_bad  = (wlast != last_beat);
    assign addr_step  = next_addr(addr_q, size_q, burst_q, len_q);
    assign ar_len_eff = (arlen > LEN_MAX) ? LEN_MAX : arlen;
    assign aw_len_eff = (awlen > LEN_MAX) ? LEN_MAX : awlen;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ar_hs) begin
                    state_next = S_RD;
                end else if (aw_hs) begin
                    state_next = S_WR;
                end
            end
            S_RD: begin
                if (r_hs && rlast) begin
                    state_next = S_IDLE;
                end
            end
            S_WR: begin
                if (w_hs && last_beat) begin
                    state_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (b_hs) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // SRAM write port: contents survive reset, so no reset branch here.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx(addr_q)][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            bvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            bid     <= '0;
            rresp   <= '0;
            bresp   <= '0;
            rdata   <= '0;
            rr_pref <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            id_q    <= '0;
            clamp_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Ready is computed one cycle ahead and dropped in the handshake cycle,
            // so each IDLE visit grants exactly one address channel.
            if (state == S_IDLE && !ar_hs && !aw_hs) begin
                arready <= arvalid && (!awvalid || !rr_pref);
                awready <= awvalid && (!arvalid || rr_pref);
            end else begin
                arready <= 1'b0;
                awready <= 1'b0;
            end

            if (ar_hs) begin
                addr_q  <= araddr;
                len_q   <= ar_len_eff;
                size_q  <= arsize;
                burst_q <= arburst;
                beat_q  <= '0;
                clamp_q <= (arlen > LEN_MAX);
                rid     <= arid;
                rresp   <= (arlen > LEN_MAX) ? RESP_SLVERR : RESP_OKAY;
                rdata   <= mem[word_idx(araddr)];
                rvalid  <= 1'b1;
                rlast   <= (ar_len_eff == 8'd0);
                rr_pref <= 1'b1;
            end

            if (aw_hs) begin
                addr_q  <= awaddr;
                len_q   <= aw_len_eff;
                size_q  <= awsize;
                burst_q <= awburst;
                beat_q  <= '0;
                clamp_q <= (awlen > LEN_MAX);
                id_q    <= awid;
                err_q   <= 1'b0;
                wready  <= 1'b1;
                rr_pref <= 1'b0;
            end

            if (r_hs) begin
                if (rlast) begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                end else begin
                    addr_q <= addr_step;
                    beat_q <= beat_q + 8'd1;
                    rdata  <= mem[word_idx(addr_step)];
                    rlast  <= ((beat_q + 8'd1) == len_q);
                end
            end

            // A wrong wlast is flagged but the beat is still stored.
            if (w_hs) begin
                err_q <= err_q | wlast_bad;
                if (last_beat) begin
                    wready <= 1'b0;
                    bvalid <= 1'b1;
                    bid    <= id_q;
                    bresp  <= (err_q || wlast_bad || clamp_q) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    addr_q <= addr_step;
                    beat_q <= beat_q + 8'd1;
                end
            end

            if (b_hs) begin
                bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder (slave) backed by an internal word-addressed SRAM array; the memory end of the CPU's AXI initiator port.
- Used as the simulation/SoC memory behind the core: serves instruction fetch and load/store bursts.
- One transaction at a time, either read or write, with round-robin arbitration between AR and AW.

Parameters:
- MEM_AW, 16, log2 of SRAM depth in 32-bit words; index = addr[MEM_AW+1:2], upper address bits ignored (aliasing).
- MAX_LEN, 16, maximum supported beats per burst; larger len is clamped to MAX_LEN beats and answered SLVERR.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/8/3/2/2/4/3  AR payload; lock/cache/prot ignored
- arvalid  in  1 ; arready  out  1
- rid  out  4 ; rdata  out  32 ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/8/3/2/2/4/3  AW payload; lock/cache/prot ignored
- awvalid  in  1 ; awready  out  1
- wid  in  4 (ignored) ; wdata  in  32 ; wstrb  in  4 ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
- bid  out  4 ; bresp  out  2 ; bvalid  out  1 ; bready  in  1

Behaviour:
- Reset (aresetn low, async): FSM -> IDLE; arready, awready, wready, rvalid, bvalid, rlast = 0; rid, bid, rresp, bresp, rdata = 0; rr_pref = read. SRAM contents are NOT reset.
- Reset mid-burst: burst abandoned, no further beats/response; memory keeps all beats written before reset.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE: arready/awready are registered and asserted only in IDLE. arready is asserted when arvalid && (!awvalid || rr_pref==read); awready is asserted in the symmetric case. Exactly one handshake per IDLE visit. rr_pref flips to the other channel after each granted transaction.
- AR handshake at cycle T: latch id, addr, len, size, burst; go to RD; first rvalid at T+1 with rdata = mem[addr].
- RD: rvalid, rdata, rlast, rid and rresp are held stable while rready=0. On each rvalid&&rready, advance to the next beat; the next beat is presented in the following cycle, so beats are back-to-back when rready stays high. rlast=1 on beat index len. After the last handshake, rvalid drops and the FSM returns to IDLE.
- AW handshake at T: latch fields; wready=1 from T+1 while in WR.
- WR: each wvalid&&wready writes mem[idx] byte lanes where wstrb[i]=1 (byte i = wdata[8i+7:8i]). Beat counter counts 0..len.
  - Write phase ends on the handshake of beat len, regardless of wlast.
  - wlast must be 1 exactly on beat len. Any mismatch sets sticky err, but the data is still written.
- WRESP: bvalid=1 the cycle after the final W beat; bid = awid; bresp = 2'b10 (SLVERR) if err or len clamp, else 2'b00. bvalid is held until bready, then the FSM returns to IDLE.
- rresp = 2'b00 except 2'b10 on every beat of a clamped burst.
- Address update per beat, on a byte address:
  - burst 00 FIXED: unchanged.
  - burst 01 INCR: addr + (1<<size).
  - burst 10 WRAP: total = (len+1)<<size; addr = (addr & ~(total-1)) | ((addr + (1<<size)) & (total-1)).
  - burst 11 is treated as INCR.
  - 32-bit arithmetic wraps modulo 2^32; the index wraps modulo 2^MEM_AW.
- Sub-word size (<2) reads return the full aligned word. Lane selection is the initiator's job.
- Simultaneous arvalid and awvalid in IDLE: only the rr_pref channel is accepted; the other waits with its ready low.
- W beats arriving before the AW handshake are not accepted (wready=0 outside WR).

Test Plan:
- Preload mem[0x100>>2..]=0x11,0x22,0x33,0x44; AR addr=0x100 len=3 size=2 INCR, rready=1 -> rvalid cycles T+1..T+4, rdata 0x11,0x22,0x33,0x44, rlast only on 4th beat, rresp=0, rid echoes arid=5.
- Same read with rready toggled 1,0,0,1,... -> rdata/rlast held stable during stalls; no beat lost or duplicated.
- AW addr=0x200 len=1 INCR, W beats 0xAABBCCDD strb=1111 then 0x12345678 strb=0011 wlast on beat 2; mem[0x204] was 0xFFFFFFFF -> mem[0x200]=0xAABBCCDD, mem[0x204]=0xFFFF5678; bvalid 1 cycle after last W beat, bresp=0, bid=awid.
- WRAP read addr=0x108 len=3 size=2 -> word addresses 0x108,0x10C,0x100,0x104.
- arvalid and awvalid asserted the same cycle, twice in a row -> first the read is served, then the write, then the read again (round-robin); write with wlast on beat 1 of len=1 -> bresp=2'b10.
- Drop aresetn for 1 cycle mid read burst -> all valid/ready outputs 0 immediately; after release, a new AR completes normally and previously written data is intact.
